axis_pkt_gen: RTL

AXI-Stream packet transmitter: on a start pulse it emits a programmable number of packets of programmable length on an 8-bit master stream, with a programmable idle gap between packets. Payload is a free-running byte counter, so a downstream receiver can check ordering and loss. It is the source end of the 8-bit tdata/tvalid/tlast/tready stream used by the stream register slice and other stream sinks in the design, and serves as both a bring-up stimulus and a traffic source.

---
 rtl/axis_pkt_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream packet source. A start pulse launches a run of
// num_pkts packets of pkt_len beats each, separated by gap_cycles idle
// cycles. The payload is a byte counter that keeps counting across packets,
// so a receiver can detect reordering or loss. Every output is decoded from
// registered state and counters only, so m_tvalid never depends on m_tready.
module axis_pkt_gen #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [CNT_W-1:0] num_pkts,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_num;
  logic [GAP_W-1:0] r_gap;
  logic [LEN_W-1:0] r_beat;
  logic [7:0]       r_payload;
  logic [CNT_W-1:0] r_pkt_count;
  logic [GAP_W-1:0] r_gap_cnt;

  logic w_xfer;
  logic w_last;
  logic w_final;
  logic w_empty;

  assign w_xfer  = (r_state == S_SEND) && m_tready;
  assign w_last  = (r_beat == (r_len - {{(LEN_W-1){1'b0}}, 1'b1}));
  assign w_final = ((r_pkt_count + {{(CNT_W-1){1'b0}}, 1'b1}) == r_num);
  // A zero length or zero count is judged on the live inputs because they
  // are the values being latched at the same edge.
  assign w_empty = (pkt_len == {LEN_W{1'b0}}) || (num_pkts == {CNT_W{1'b0}});

  // Next-state decode for the run sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = w_empty ? S_FIN : S_SEND;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SEND: begin
        if (w_xfer && w_last) begin
          if (w_final) begin
            w_state_next = S_FIN;
          end else if (r_gap == {GAP_W{1'b0}}) begin
            w_state_next = S_SEND;
          end else begin
            w_state_next = S_GAP;
          end
        end else begin
          w_state_next = S_SEND;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == {GAP_W{1'b0}}) begin
          w_state_next = S_SEND;
        end else begin
          w_state_next = S_GAP;
        end
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Configuration latch, beat/payload/packet counters and gap down-counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_len       <= {LEN_W{1'b0}};
      r_num       <= {CNT_W{1'b0}};
      r_gap       <= {GAP_W{1'b0}};
      r_beat      <= {LEN_W{1'b0}};
      r_payload   <= 8'd0;
      r_pkt_count <= {CNT_W{1'b0}};
      r_gap_cnt   <= {GAP_W{1'b0}};
    end else if ((r_state == S_IDLE) && start) begin
      r_len       <= pkt_len;
      r_num       <= num_pkts;
      r_gap       <= gap_cycles;
      r_beat      <= {LEN_W{1'b0}};
      r_payload   <= 8'd0;
      r_pkt_count <= {CNT_W{1'b0}};
      r_gap_cnt   <= {GAP_W{1'b0}};
    end else begin
      if (w_xfer) begin
        r_payload <= r_payload + 8'd1;
        if (w_last) begin
          r_beat      <= {LEN_W{1'b0}};
          r_pkt_count <= r_pkt_count + {{(CNT_W-1){1'b0}}, 1'b1};
          // Loaded one below the gap so that GAP lasts exactly gap cycles
          // (the terminal cycle is the one that sees zero).
          r_gap_cnt   <= r_gap - {{(GAP_W-1){1'b0}}, 1'b1};
        end else begin
          r_beat <= r_beat + {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end else if ((r_state == S_GAP) && (r_gap_cnt != {GAP_W{1'b0}})) begin
        r_gap_cnt <= r_gap_cnt - {{(GAP_W-1){1'b0}}, 1'b1};
      end else begin
        r_gap_cnt <= r_gap_cnt;
      end
    end
  end

  assign m_tvalid  = (r_state == S_SEND);
  assign m_tdata   = r_payload;
  assign m_tlast   = (r_state == S_SEND) && w_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign pkt_count = r_pkt_count;

endmodule
